param_load_ctrl: RTL and testbench
==================================

// Module: param_load_ctrl
// PURPOSE
//   Sequencer that loads the neuron parameter shift register (4 neurons x 6 bytes) from a byte stream.
//   Accepts bytes over a valid/ready handshake and drives the register's selector/data_in pair.
//   Counts the parameters and flags a complete load, a timeout or a checksum failure.
//   Sits between the host byte interface and the parameter register.
// PARAMETERS
//   NUM_PARAMS      24   bytes per full load; wraps into CNT_W = $clog2(NUM_PARAMS+1) bits
//   DATA_W          8    byte width
//   TIMEOUT_CYCLES  255  max idle cycles in LOAD between accepted bytes before aborting (>=1)
// PORTS
//   clk           in   1       rising-edge clock
//   reset_n       in   1       asynchronous active-low reset
//   start         in   1       pulse: begin a new load (honoured in IDLE only)
//   abort         in   1       level: cancel load, return to IDLE
//   in_data       in   DATA_W  parameter byte
//   in_valid      in   1       in_data valid
//   in_ready      out  1       controller can take a byte
//   sel           out  2       selector to parameter register: 2'b00 hold, 2'b11 full-chain shift
//   shift_data    out  DATA_W  data_in to parameter register
//   busy          out  1       1 in LOAD/CHECK
//   params_valid  out  1       last load completed correctly
//   load_error    out  1       last load ended by timeout or checksum mismatch
//   load_count    out  CNT_W   bytes shifted in current/last load
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, all outputs 0 (sel=2'b00, shift_data=0, count=0).
//   States: IDLE -> LOAD -> [CHECK] -> DONE -> IDLE.
//   IDLE: in_ready=0, sel=00. start=1 && abort=0 -> LOAD; clear load_count, params_valid, load_error, timer.
//   LOAD: in_ready = ~abort (combinational). Accept = in_valid && in_ready.
//     Accept in cycle N -> registered sel=2'b11, shift_data=in_data in cycle N+1 (1-cycle latency);
//       register shifts on the edge ending N+1. Any cycle without accept: sel=2'b00 next cycle.
//     load_count increments per accept; the NUM_PARAMS-th accept -> DONE (or CHECK if CHECKSUM_EN).
//     Timer counts cycles without accept and resets on accept. It reaching TIMEOUT_CYCLES -> IDLE with
//       load_error=1 and params_valid=0; load_count holds the partial value.
//   DONE: one cycle, params_valid=1, busy=0; then IDLE with params_valid held until next start.
//   abort=1 in LOAD/CHECK: in_ready=0 same cycle; next state IDLE; no byte is accepted; no error set;
//     params_valid=0. A shift already registered still issues (sel=11 for that one cycle).
//   start ignored outside IDLE. start with abort in IDLE: abort wins, stay IDLE.
//   Timeout and accept in the same cycle: accept wins, timer cleared.
//   Reset mid-load: immediate IDLE, outputs 0; parameter register contents are not guaranteed.
// CONFIGURATION
//   PARAM_LOAD_CHECKSUM_EN defined: after NUM_PARAMS bytes enter CHECK, in_ready=1, and accept one more
//     byte with sel=00 (not shifted, not counted). Byte == 8-bit sum mod 256 of the params -> DONE.
//     Mismatch -> IDLE with load_error=1, params_valid=0. Timeout/abort rules also apply in CHECK.
//   Undefined: no CHECK state and no sum logic; DONE follows the NUM_PARAMS-th accept.
// TESTING
//   1 Reset, start, 24 back-to-back bytes 0x01..0x18 -> 24 sel=11 cycles, each one cycle after its accept,
//     with shift_data matching; params_valid=1, load_count=24, busy=0.
//   2 Bytes with random in_valid gaps < TIMEOUT -> sel=11 only after accepts, otherwise sel=00; same final state.
//   3 Send 10 bytes, then idle TIMEOUT_CYCLES -> load_error=1, params_valid=0, load_count=10, state IDLE.
//   4 abort on the 5th byte's valid cycle -> in_ready=0 that cycle, 4 shifts total, IDLE, load_error=0.
//   5 CHECKSUM_EN: bytes 0x01..0x18 then 0x2C -> params_valid=1. Repeat with 0x2D -> load_error=1.
//   6 reset_n low mid-LOAD -> all outputs 0 asynchronously. start during LOAD -> no effect on count.

Source files
------------

// File: rtl/param_load_ctrl_if.sv
// Host byte stream into the parameter load controller: a plain valid/ready handshake.
// The host drives data and valid. The controller answers with ready.
interface param_load_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/param_load_ctrl.sv
// param_load_ctrl: sequences a byte stream into the neuron parameter shift register.
// The register holds 4 neurons x 6 bytes.
// Each accepted byte becomes a full-chain shift (sel=11) exactly one cycle later.
// Optional feature macro: PARAM_LOAD_CHECKSUM_EN. When it is defined, the controller takes
// one trailing byte after the parameters. That byte must equal the 8-bit sum of the loaded bytes.
module param_load_ctrl #(
  parameter int  NUM_PARAMS     = 24,
  parameter int  DATA_W         = 8,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int CNT_W          = $clog2(NUM_PARAMS + 1),
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  param_load_ctrl_if.slave      host,
  output logic [1:0]            sel,
  output logic [DATA_W-1:0]     shift_data,
  output logic                  busy,
  output logic                  params_valid,
  output logic                  load_error,
  output logic [CNT_W-1:0]      load_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2
`ifdef PARAM_LOAD_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [TMR_W-1:0]   timer, tmr_n;
  logic               pv_n, err_n;
  logic               rdy, take;
  logic               shift_vld;
`ifdef PARAM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]  sum, sum_n;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PARAMS - 1);
  localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT_CYCLES - 1);

  assign host.in_ready = rdy;
  assign sel           = {2{shift_vld}};
`ifdef PARAM_LOAD_CHECKSUM_EN
  assign busy          = (state == S_LOAD) || (state == S_CHECK);
`else
  assign busy          = (state == S_LOAD);
`endif

  // Next-state, counters, flags and handshake.
  always_comb begin
    state_n = state;
    cnt_n   = load_count;
    tmr_n   = timer;
    pv_n    = params_valid;
    err_n   = load_error;
    rdy     = 1'b0;
    take    = 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
    sum_n   = sum;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          tmr_n   = '0;
          pv_n    = 1'b0;
          err_n   = 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
          sum_n   = '0;
`endif
        end
      end
      S_LOAD: begin
        rdy = !abort;
        if (abort) begin
          // Cancelling a load is not an error. A shift registered last cycle still drains.
          state_n = S_IDLE;
          pv_n    = 1'b0;
        end else if (host.in_valid) begin
          // An accept always beats a timeout in the same cycle.
          take  = 1'b1;
          cnt_n = load_count + 1'b1;
          tmr_n = '0;
`ifdef PARAM_LOAD_CHECKSUM_EN
          sum_n = sum + host.in_data;
          if (load_count == LAST_CNT) state_n = S_CHECK;
`else
          if (load_count == LAST_CNT) begin
            state_n = S_DONE;
            pv_n    = 1'b1;
          end
`endif
        end else if (timer == LAST_TMR) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          pv_n    = 1'b0;
        end else begin
          tmr_n = timer + 1'b1;
        end
      end
`ifdef PARAM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        // The checksum byte is consumed but never shifted or counted.
        rdy = !abort;
        if (abort) begin
          state_n = S_IDLE;
          pv_n    = 1'b0;
        end else if (host.in_valid) begin
          tmr_n = '0;
          if (host.in_data == sum) begin
            state_n = S_DONE;
            pv_n    = 1'b1;
          end else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            pv_n    = 1'b0;
          end
        end else if (timer == LAST_TMR) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          pv_n    = 1'b0;
        end else begin
          tmr_n = timer + 1'b1;
        end
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      load_count   <= '0;
      timer        <= '0;
      params_valid <= 1'b0;
      load_error   <= 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      state        <= state_n;
      load_count   <= cnt_n;
      timer        <= tmr_n;
      params_valid <= pv_n;
      load_error   <= err_n;
`ifdef PARAM_LOAD_CHECKSUM_EN
      sum          <= sum_n;
`endif
    end
  end

  // One-cycle shift stage: an accepted byte drives the register on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_vld  <= 1'b0;
      shift_data <= '0;
    end else begin
      shift_vld <= take;
      if (take) shift_data <= host.in_data;
    end
  end

endmodule

// File: tb/tb_param_load_ctrl.sv
// Randomized self-checking bench for param_load_ctrl.
// A behavioural model predicts every output on every cycle.
// Literal expectations after the directed loads pin the model itself.
module tb_param_load_ctrl;
  localparam int NP = 24;
  localparam int DW = 8;
  localparam int TO = 255;
  localparam int CW = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    sel;
  logic [DW-1:0] shift_data;
  logic          busy, params_valid, load_error;
  logic [CW-1:0] load_count;

  param_load_ctrl_if #(.DATA_W(DW)) bus ();

  param_load_ctrl #(.NUM_PARAMS(NP), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .host(bus),
    .sel(sel), .shift_data(shift_data), .busy(busy), .params_valid(params_valid),
    .load_error(load_error), .load_count(load_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 collecting params, 2 awaiting checksum, 3 completion cycle.
  int m_phase = 0, m_cnt = 0, m_idle = 0, m_sum = 0, m_sd = 0, m_shifts = 0;
  bit m_pv = 0, m_err = 0, m_pend = 0;
`ifdef PARAM_LOAD_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Compare every output against the model each cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    bit acc;
    bit rdy_e;
    if (!reset_n) begin
      m_phase = 0; m_cnt = 0; m_idle = 0; m_sum = 0; m_sd = 0;
      m_pv = 0; m_err = 0; m_pend = 0;
    end
    rdy_e = (m_phase == 1 || m_phase == 2) && !abort;
    check("in_ready", int'(bus.in_ready), int'(rdy_e));
    check("sel", int'(sel), m_pend ? 3 : 0);
    if (m_pend) check("shift_data", int'(shift_data), m_sd);
    check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    check("params_valid", int'(params_valid), int'(m_pv));
    check("load_error", int'(load_error), int'(m_err));
    check("load_count", int'(load_count), m_cnt);
    if (reset_n) begin
      acc = bus.in_valid && rdy_e;
      m_pend = acc && (m_phase == 1);
      if (m_pend) begin
        m_sd = int'(bus.in_data);
        m_shifts++;
      end
      case (m_phase)
        0: if (start && !abort) begin
             m_phase = 1; m_cnt = 0; m_pv = 0; m_err = 0; m_idle = 0; m_sum = 0;
           end
        1, 2: begin
          if (abort) m_phase = 0;
          else if (acc) begin
            m_idle = 0;
            if (m_phase == 1) begin
              m_cnt++;
              m_sum = (m_sum + int'(bus.in_data)) % 256;
              if (m_cnt == NP) begin
                m_phase = CHK ? 2 : 3;
                if (!CHK) m_pv = 1;
              end
            end else if (int'(bus.in_data) == m_sum) begin
              m_phase = 3; m_pv = 1;
            end else begin
              m_phase = 0; m_err = 1;
            end
          end else begin
            m_idle++;
            if (m_idle == TO) begin m_phase = 0; m_err = 1; end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic cyc(bit s, bit a, bit v, logic [DW-1:0] d);
    start = s; abort = a; bus.in_valid = v; bus.in_data = d;
    @(posedge clk); #1;
  endtask

  // Start a load and send n bytes (incrementing or random), optionally with random gaps
  // (stray start pulses included) and, when the checksum is built in, the matching sum byte.
  task automatic load_seq(int n, bit gaps, bit inc, bit send_sum);
    int s = 0;
    logic [DW-1:0] d;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        if (i == 10) repeat (TO - 1) cyc(0, 0, 0, 8'($urandom));
        else repeat ($urandom_range(0, 4)) cyc($urandom_range(0, 3) == 0, 0, 0, 8'($urandom));
      end
      d = inc ? DW'(i + 1) : DW'($urandom);
      s += int'(d);
      cyc(0, 0, 1, d);
    end
    if (CHK && send_sum) cyc(0, 0, 1, DW'(s % 256));
    repeat (3) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int sh0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", int'(sel), 0);
    check("rst_count", int'(load_count), 0);
    check("rst_pv", int'(params_valid), 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Back-to-back load of 0x01..0x18.
    sh0 = m_shifts;
    load_seq(NP, 0, 1, 1);
    check("t1_shifts", m_shifts - sh0, 24);
    check("t1_pv", int'(params_valid), 1);
    check("t1_count", int'(load_count), 24);
    check("t1_busy", int'(busy), 0);

    // Random gaps, one of them TO-1 cycles long (just short of a timeout).
    load_seq(NP, 1, 0, 1);
    check("t2_pv", int'(params_valid), 1);
    check("t2_err", int'(load_error), 0);
    check("t2_count", int'(load_count), 24);

    // Timeout after 10 bytes: still loading after TO-1 idle cycles, aborted after TO.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, DW'(i + 7));
    repeat (TO - 1) cyc(0, 0, 0, 0);
    check("t3_busy_pre", int'(busy), 1);
    cyc(0, 0, 0, 0);
    check("t3_busy", int'(busy), 0);
    check("t3_err", int'(load_error), 1);
    check("t3_pv", int'(params_valid), 0);
    check("t3_count", int'(load_count), 10);

    // Abort on the 5th byte's valid cycle.
    sh0 = m_shifts;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, DW'(i + 1));
    start = 0; abort = 1; bus.in_valid = 1; bus.in_data = 8'h55;
    #1 check("t4_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    repeat (3) cyc(0, 0, 0, 0);
    check("t4_shifts", m_shifts - sh0, 4);
    check("t4_count", int'(load_count), 4);
    check("t4_err", int'(load_error), 0);
    check("t4_busy", int'(busy), 0);

`ifdef PARAM_LOAD_CHECKSUM_EN
    // Correct (0x2C) and wrong (0x2D) checksum after 0x01..0x18.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < NP; i++) cyc(0, 0, 1, DW'(i + 1));
    cyc(0, 0, 1, 8'h2C);
    repeat (2) cyc(0, 0, 0, 0);
    check("t5_pv", int'(params_valid), 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < NP; i++) cyc(0, 0, 1, DW'(i + 1));
    cyc(0, 0, 1, 8'h2D);
    repeat (2) cyc(0, 0, 0, 0);
    check("t5_err", int'(load_error), 1);
    check("t5_pv_bad", int'(params_valid), 0);
`endif

    // start during a load is ignored, then reset mid-load clears outputs asynchronously.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, DW'(8'hA0 + i));
    repeat (3) cyc(1, 0, 0, 0);
    check("t6_count", int'(load_count), 6);
    cyc(0, 0, 1, 8'h77);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_sel", int'(sel), 0);
    check("t6_rst_count", int'(load_count), 0);
    check("t6_rst_data", int'(shift_data), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Free-running random traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) != 0, DW'($urandom));
    repeat (3) cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
